seg_scan_decoder: RTL

//  Receive-side monitor for the multiplexed 4-digit 7-segment bus (AN/SEG) driven by the display block.

---
 rtl/seg_scan_decoder_if.sv | 21 ++
 rtl/seg_scan_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder_if.sv
// Bus between a 7-segment scan source and the scan decoder: the AN/SEG scan
// plus the recovered word, decimal points and status flags.
interface seg_scan_decoder_if;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic [15:0] dat;
    logic [3:0]  dp;
    logic        frame_stb;
    logic        valid;
    logic        err;

    modport master (
        output AN, SEG,
        input  dat, dp, frame_stb, valid, err
    );

    modport slave (
        input  AN, SEG,
        output dat, dp, frame_stb, valid, err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment scan: debounces each
// lit digit, decodes it back to a hex nibble and reassembles complete frames.
module seg_scan_decoder #(
    parameter int STABLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 150000
) (
    input  logic                clk,
    input  logic                R,
    seg_scan_decoder_if.slave   bus
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_LOAD    = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
        return (v == TO_MAX) ? v : v + TO_W'(1);
    endfunction

    function automatic logic an_onehot_low(input logic [3:0] an);
        logic [3:0] lit;
        lit = ~an;
        return (lit != 4'd0) && ((lit & (lit - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Returns {hit, nibble}; pattern is active-high gfedcba.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    logic [3:0]       r_an_p0;
    logic [7:0]       r_seg_p0;
    logic [3:0]       r_an_p1;
    logic [7:0]       r_seg_p1;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [3:0]       r_mask;
    logic [15:0]      r_shadow_dat;
    logic [3:0]       r_shadow_dp;
    logic [15:0]      r_dat;
    logic [3:0]       r_dp;
    logic             r_valid;
    logic             r_err;
    state_t           r_state;

    logic             w_same;
    logic             w_accept;
    logic             w_onehot;
    logic [4:0]       w_dec;
    logic             w_capture;
    logic             w_bad;
    logic [1:0]       w_idx;
    logic             w_timeout;
    logic             w_drop;
    logic             w_load;
    logic [3:0]       w_mask_nxt;
    state_t           w_state_nxt;

    // Stage p0: input register; stage p1: previous sample for the stability compare
    always_ff @(posedge clk) begin
        r_an_p0  <= bus.AN;
        r_seg_p0 <= bus.SEG;
        r_an_p1  <= r_an_p0;
        r_seg_p1 <= r_seg_p0;
    end

    assign w_same    = (r_an_p0 == r_an_p1) && (r_seg_p0 == r_seg_p1);
    assign w_accept  = w_same && (r_cnt == CNT_ACC);
    assign w_onehot  = an_onehot_low(r_an_p0);
    assign w_dec     = seg_decode(~r_seg_p0[6:0]);
    assign w_idx     = an_index(r_an_p0);
    assign w_capture = w_accept && w_onehot && w_dec[4];
    assign w_bad     = w_accept && w_onehot && !w_dec[4];
    assign w_timeout = (r_to_cnt == TO_MAX);
    // A capture in the same clock as the timeout wins over the timeout.
    assign w_drop    = w_timeout && !w_capture;

    always_ff @(posedge clk) begin
        if (R) begin
            r_cnt    <= '0;
            r_to_cnt <= '0;
        end else begin
            r_cnt    <= w_same ? cnt_sat_inc(r_cnt) : '0;
            r_to_cnt <= w_capture ? '0 : to_sat_inc(r_to_cnt);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_drop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_mask == 4'hF) begin
                    w_state_nxt = S_LOAD;
                    w_load      = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nxt = w_drop ? S_IDLE : S_COLLECT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (R) r_state <= S_IDLE;
        else   r_state <= w_state_nxt;
    end

    always_comb begin
        w_mask_nxt = r_mask;
        if (w_load || w_drop) w_mask_nxt = 4'h0;
        if (w_capture)        w_mask_nxt[w_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (R) r_mask <= 4'h0;
        else   r_mask <= w_mask_nxt;
    end

    // Shadow is not reset: a cleared mask forces every nibble to be rewritten.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_shadow_dat[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
            r_shadow_dp[w_idx]                <= ~r_seg_p0[7];
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_dat   <= 16'h0000;
            r_dp    <= 4'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_dat <= r_shadow_dat;
                r_dp  <= r_shadow_dp;
            end
            if (w_load)      r_valid <= 1'b1;
            else if (w_drop) r_valid <= 1'b0;
            if (w_bad)       r_err <= 1'b1;
        end
    end

    assign bus.dat       = r_dat;
    assign bus.dp        = r_dp;
    assign bus.frame_stb = (r_state == S_LOAD);
    assign bus.valid     = r_valid;
    assign bus.err       = r_err;

endmodule
